// File: rtl/store_buffer_pkg.sv
// Shared types for the CPU store path.
package store_buffer_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_dt_e;

endpackage

// File: rtl/store_buffer.sv
// Word-aligned store queue between the CPU data port and cpu_mem, with
// same-word merging into the youngest entry and per-byte load forwarding.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter bit          MERGE_EN = 1'b1,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [31:0]              st_wd,
   input  mem_dt_e                  st_dt,
   output logic                     st_err,
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic [3:0]               ld_fwd_be,
   output logic [31:0]              ld_fwd_data,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [31:0]              mem_wd,
   output logic [3:0]               mem_be,
   input  logic                     mem_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned WA_W = ADDR_W - 2;

   logic [WA_W-1:0] e_waddr [DEPTH];
   logic [31:0]     e_data  [DEPTH];
   logic [3:0]      e_be    [DEPTH];

   logic [PW-1:0]   head_q;
   logic [PW-1:0]   tail_q;
   logic [CW-1:0]   count_q;
   logic            st_err_q;

   logic [1:0]      st_off;
   logic [3:0]      in_be;
   logic [31:0]     in_data;
   logic            misalign;
   logic [WA_W-1:0] in_waddr;
   logic [PW-1:0]   youngest;
   logic [31:0]     merged_data;
   logic            accept;
   logic            do_merge;
   logic            push;
   logic            pop;
   logic [PW-1:0]   fwd_idx;
   logic            unused_ld;

   // Position the right-aligned store data into its byte lanes.
   always_comb begin
      st_off   = st_addr[1:0];
      in_be    = 4'b0000;
      in_data  = 32'h0;
      misalign = 1'b0;
      case (st_dt)
         MEM_BYTE: begin
            in_be   = 4'b0001 << st_off;
            in_data = {24'h0, st_wd[7:0]} << {st_off, 3'b000};
         end
         MEM_HALF: begin
            if (st_off[0]) begin
               misalign = 1'b1;
            end else begin
               in_be   = 4'b0011 << st_off;
               in_data = {16'h0, st_wd[15:0]} << {st_off, 3'b000};
            end
         end
         MEM_WORD: begin
            if (st_off != 2'b00) begin
               misalign = 1'b1;
            end else begin
               in_be   = 4'b1111;
               in_data = st_wd;
            end
         end
         default: misalign = 1'b1;
      endcase
   end

   assign in_waddr = st_addr[ADDR_W-1:2];
   assign youngest = tail_q - PW'(1);
   assign accept   = st_valid && st_ready;
   assign pop      = mem_we && mem_ready;

   // With two or more entries the youngest can never be the head, so merging is safe under a pop.
   assign do_merge = MERGE_EN && accept && !misalign && (count_q >= CW'(2))
                     && (e_waddr[youngest] == in_waddr);
   assign push     = accept && !misalign && !do_merge;

   always_comb begin
      merged_data = e_data[youngest];
      for (int l = 0; l < 4; l++) begin
         if (in_be[l]) begin
            merged_data[8*l +: 8] = in_data[8*l +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         st_err_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            e_waddr[i] <= '0;
            e_data[i]  <= '0;
            e_be[i]    <= '0;
         end
      end else begin
         st_err_q <= accept && misalign;
         if (push) begin
            e_waddr[tail_q] <= in_waddr;
            e_data[tail_q]  <= in_data;
            e_be[tail_q]    <= in_be;
            tail_q          <= tail_q + PW'(1);
         end
         if (do_merge) begin
            e_data[youngest] <= merged_data;
            e_be[youngest]   <= e_be[youngest] | in_be;
         end
         if (pop) begin
            head_q <= head_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // Walk oldest to youngest so the youngest matching entry wins each lane.
   always_comb begin
      ld_fwd_be   = 4'b0000;
      ld_fwd_data = 32'h0;
      fwd_idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head_q + PW'(k);
         if ((CW'(k) < count_q) && (e_waddr[fwd_idx] == ld_addr[ADDR_W-1:2])) begin
            for (int l = 0; l < 4; l++) begin
               if (e_be[fwd_idx][l]) begin
                  ld_fwd_be[l]          = 1'b1;
                  ld_fwd_data[8*l +: 8] = e_data[fwd_idx][8*l +: 8];
               end
            end
         end
      end
   end

   assign unused_ld = ^ld_addr[1:0];

   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign st_ready = (count_q != CW'(DEPTH));
   assign st_err   = st_err_q;
   assign mem_we   = (count_q != '0);
   assign mem_addr = {e_waddr[head_q], 2'b00};
   assign mem_wd   = e_data[head_q];
   assign mem_be   = e_be[head_q];

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: one merging and one non-merging instance
// share stimulus; expected values are hand-computed.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned CW = 3;

   logic          clk;
   logic          rst;
   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [31:0]   st_wd;
   mem_dt_e       st_dt;
   logic [AW-1:0] ld_addr;
   logic          mem_ready;

   logic          st_ready_a, st_err_a, mem_we_a, empty_a;
   logic [3:0]    ld_fwd_be_a, mem_be_a;
   logic [31:0]   ld_fwd_data_a, mem_wd_a;
   logic [AW-1:0] mem_addr_a;
   logic [CW-1:0] count_a;

   logic          st_ready_b, st_err_b, mem_we_b, empty_b;
   logic [3:0]    ld_fwd_be_b, mem_be_b;
   logic [31:0]   ld_fwd_data_b, mem_wd_b;
   logic [AW-1:0] mem_addr_b;
   logic [CW-1:0] count_b;

   int n_checks;
   int n_fail;

   store_buffer #(.DEPTH(4), .MERGE_EN(1'b1), .ADDR_W(AW)) dut_a (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready_a),
      .st_addr(st_addr), .st_wd(st_wd), .st_dt(st_dt), .st_err(st_err_a),
      .ld_addr(ld_addr), .ld_fwd_be(ld_fwd_be_a), .ld_fwd_data(ld_fwd_data_a),
      .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wd(mem_wd_a), .mem_be(mem_be_a),
      .mem_ready(mem_ready), .count(count_a), .empty(empty_a)
   );

   store_buffer #(.DEPTH(4), .MERGE_EN(1'b0), .ADDR_W(AW)) dut_b (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready_b),
      .st_addr(st_addr), .st_wd(st_wd), .st_dt(st_dt), .st_err(st_err_b),
      .ld_addr(ld_addr), .ld_fwd_be(ld_fwd_be_b), .ld_fwd_data(ld_fwd_data_b),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wd(mem_wd_b), .mem_be(mem_be_b),
      .mem_ready(mem_ready), .count(count_b), .empty(empty_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one store until the merging instance accepts it.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input mem_dt_e t);
      st_addr  = a;
      st_wd    = d;
      st_dt    = t;
      st_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (st_ready_a) begin
            tick();
            st_valid = 1'b0;
            return;
         end
         tick();
      end
      st_valid = 1'b0;
      check("store_timeout", 0, 1);
   endtask

   task automatic drain();
      mem_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (empty_a && empty_b) break;
         tick();
      end
      mem_ready = 1'b0;
      check("drain_empty", 64'(empty_a && empty_b), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      st_valid  = 1'b0;
      st_addr   = '0;
      st_wd     = '0;
      st_dt     = MEM_WORD;
      ld_addr   = '0;
      mem_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_count", count_a, 0);
      check("rst_empty", empty_a, 1);
      check("rst_st_ready", st_ready_a, 1);
      check("rst_mem_we", mem_we_a, 0);
      check("rst_st_err", st_err_a, 0);
      check("rst_count_b", count_b, 0);

      // sh into empty buffer, popped on first ready
      store(32'h1014, 32'hdeadc0de, MEM_HALF);
      check("sh0_mem_we", mem_we_a, 1);
      check("sh0_mem_addr", mem_addr_a, 32'h1014);
      check("sh0_mem_be", mem_be_a, 4'b0011);
      check("sh0_mem_wd", mem_wd_a, 32'h0000c0de);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("sh0_empty", empty_a, 1);
      check("sh0_mem_we_off", mem_we_a, 0);
      check("sh0_empty_b", empty_b, 1);

      // upper-half store held under backpressure
      store(32'h1022, 32'hdeadbeef, MEM_HALF);
      for (int i = 0; i < 3; i++) begin
         check("sh2_mem_addr", mem_addr_a, 32'h1020);
         check("sh2_mem_be", mem_be_a, 4'b1100);
         check("sh2_mem_wd", mem_wd_a, 32'hbeef0000);
         tick();
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("sh2_empty", empty_a, 1);

      // merge vs. no-merge
      store(32'h1000, 32'h11111111, MEM_WORD);
      store(32'h1004, 32'h000000aa, MEM_BYTE);
      store(32'h1005, 32'h000000bb, MEM_BYTE);
      store(32'h1006, 32'h0000c0de, MEM_HALF);
      ld_addr = 32'h1004;
      #1;
      check("mrg_count", count_a, 2);
      check("nomrg_count", count_b, 4);
      check("nomrg_st_ready", st_ready_b, 0);
      check("mrg_fwd_be", ld_fwd_be_a, 4'hf);
      check("mrg_fwd_data", ld_fwd_data_a, 32'hc0debbaa);
      check("nomrg_fwd_be", ld_fwd_be_b, 4'hf);
      check("nomrg_fwd_data", ld_fwd_data_b, 32'hc0debbaa);
      check("mrg_head_wd", mem_wd_a, 32'h11111111);

      // youngest-wins forwarding; non-merging instance is full and stalls
      store(32'h1001, 32'h00000077, MEM_BYTE);
      ld_addr = 32'h1000;
      #1;
      check("yw_count_a", count_a, 3);
      check("stall_count_b", count_b, 4);
      check("yw_fwd_be", ld_fwd_be_a, 4'hf);
      check("yw_fwd_data", ld_fwd_data_a, 32'h11117711);
      ld_addr = 32'h1008;
      #1;
      check("miss_fwd_be", ld_fwd_be_a, 4'h0);
      check("miss_fwd_data", ld_fwd_data_a, 32'h0);
      check("full_head_addr_b", mem_addr_b, 32'h1000);

      // one pop frees a slot; drain in program order
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("pop1_count_b", count_b, 3);
      check("pop1_st_ready_b", st_ready_b, 1);
      check("pop1_count_a", count_a, 2);
      check("pop1_addr_b", mem_addr_b, 32'h1004);
      check("pop1_be_b", mem_be_b, 4'b0001);
      check("pop1_wd_b", mem_wd_b, 32'h000000aa);
      check("pop1_addr_a", mem_addr_a, 32'h1004);
      check("pop1_be_a", mem_be_a, 4'hf);
      check("pop1_wd_a", mem_wd_a, 32'hc0debbaa);
      mem_ready = 1'b1;
      tick();
      check("pop2_be_b", mem_be_b, 4'b0010);
      check("pop2_wd_b", mem_wd_b, 32'h0000bb00);
      check("pop2_addr_a", mem_addr_a, 32'h1000);
      check("pop2_be_a", mem_be_a, 4'b0010);
      check("pop2_wd_a", mem_wd_a, 32'h00007700);
      tick();
      check("pop3_be_b", mem_be_b, 4'b1100);
      check("pop3_wd_b", mem_wd_b, 32'hc0de0000);
      check("pop3_empty_a", empty_a, 1);
      tick();
      mem_ready = 1'b0;
      check("pop4_empty_b", empty_b, 1);

      // same-word store onto a lone head entry must allocate, not merge
      store(32'h3000, 32'h00000011, MEM_BYTE);
      store(32'h3001, 32'h00000022, MEM_BYTE);
      check("nohead_count", count_a, 2);
      check("nohead_be", mem_be_a, 4'b0001);
      check("nohead_wd", mem_wd_a, 32'h00000011);
      drain();

      // misaligned stores are dropped with a one-cycle error pulse
      store(32'h1001, 32'h00001234, MEM_HALF);
      check("mis_h_err", st_err_a, 1);
      check("mis_h_count", count_a, 0);
      check("mis_h_mem_we", mem_we_a, 0);
      tick();
      check("mis_h_err_clr", st_err_a, 0);
      store(32'h1002, 32'h12345678, MEM_WORD);
      check("mis_w_err", st_err_a, 1);
      check("mis_w_mem_we", mem_we_a, 0);
      tick();
      check("mis_w_err_clr", st_err_a, 0);
      check("mis_w_count", count_a, 0);

      // streaming with pop every cycle wraps the pointers
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         store(32'h2000 + 32'(4 * i), 32'(i), MEM_WORD);
         check("wrap_mem_we", mem_we_a, 1);
         check("wrap_mem_addr", mem_addr_a, 32'h2000 + 32'(4 * i));
         check("wrap_mem_wd", mem_wd_a, 32'(i));
         check("wrap_count", count_a, 1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_mem_we", mem_we_a, 0);
      check("midrst_count", count_a, 0);
      tick();
      check("midrst_mem_we_hold", mem_we_a, 0);
      mem_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Parametrised write buffer between the CPU data port and cpu_mem. It is the successor to the single-cycle byte/half/word store path.
- Accepts sb/sh/sw requests and converts each to a word-aligned write with a byte-enable mask.
- Queues up to DEPTH writes and optionally merges same-word stores.
- Forwards buffered bytes to loads and drains to memory with a valid/ready handshake.

Parameters:
DEPTH, 4, number of entries; power of two, 2..16
MERGE_EN, 1, 1 = a store to the same word as the youngest non-head entry merges into it
ADDR_W, 32, byte address width; data width fixed at 32

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
st_valid  in  1  store request
st_ready  out  1  buffer can accept; equals !full
st_addr  in  ADDR_W  byte address
st_wd  in  32  store data, right-aligned (rs2 value)
st_dt  in  mem_dt_e  access size: byte / half / word
st_err  out  1  one-cycle pulse: previous accepted-handshake store was misaligned
ld_addr  in  ADDR_W  load byte address for forwarding lookup
ld_fwd_be  out  4  per-lane hit mask for ld_addr's word
ld_fwd_data  out  32  forwarded lanes (youngest entry wins per byte); 0 in non-hit lanes
mem_we  out  1  head entry valid
mem_addr  out  ADDR_W  head word address, [1:0] = 0
mem_wd  out  32  head lane-positioned data
mem_be  out  4  head byte enables
mem_ready  in  1  memory accepts head this cycle
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count == 0; used for fence / drain-before-load-miss

Behaviour:
- Reset state (next posedge with rst=1): count=0, all entries invalid, mem_we=0, st_err=0, st_ready=1, empty=1. Reset mid-drain discards all entries; no further mem_we until a new store.
- Store handshake:
  - Accepted when st_valid && st_ready at posedge.
  - Lane mapping uses o = st_addr[1:0]:
    - byte: be = 1<<o, data = st_wd[7:0] << 8*o.
    - half: requires o[0]=0; be = 2'b11 << o, data = st_wd[15:0] << 8*o.
    - word: requires o=0; be = 4'hf.
  - Misaligned store: handshake completes but nothing is enqueued. st_err=1 for exactly the following cycle.
- Merge (MERGE_EN=1):
  - Applies if the incoming word address equals the youngest entry's word address, count >= 2, and that entry is not the head.
  - New enabled lanes overwrite that entry's data; be |= new be; count unchanged.
  - Otherwise, and always when MERGE_EN=0, the store allocates at tail.
- Drain:
  - mem_we = !empty. mem_addr, mem_wd and mem_be come from the head and are stable while mem_we && !mem_ready.
  - Head pops on the posedge where mem_we && mem_ready.
  - Latency: a store into an empty buffer gives mem_we=1 the cycle after acceptance; no same-cycle bypass.
- Simultaneous enqueue and pop: count unchanged; pointers both advance and wrap modulo DEPTH.
- Full: st_ready=0 even if mem_ready is high that cycle (no ready-to-ready combinational path). A pop while full frees a slot for the next cycle.
- Merge and pop in the same cycle: merge still applies to the youngest entry, which by rule is not the head.
- Forwarding:
  - Combinational over all valid entries, including the head.
  - Per lane, take the youngest entry whose word address matches ld_addr[ADDR_W-1:2] and whose be bit is set.
  - Forwarding reflects register state only; a store accepted this same cycle is not visible.
- Entry data field: any lane with be=0 holds 0.

Test Plan:
- Reset then sh 0xdeadc0de to 0x1014 -> next cycle mem_we=1, mem_addr=0x1014, mem_be=4'b0011, mem_wd=0x0000c0de; mem_ready=1 pops; empty=1 one cycle later.
- sh 0xdeadbeef to 0x1022 with mem_ready=0 -> mem_addr=0x1020, mem_be=4'b1100, mem_wd=0xbeef0000, held stable 3 cycles until mem_ready=1.
- mem_ready=0; sw 0x11111111 @0x1000, sb 0xaa @0x1004, sb 0xbb @0x1005, sh 0xc0de @0x1006 (MERGE_EN=1) -> count=2; second entry be=4'hf, data=0xc0debbaa. ld_addr=0x1004 gives ld_fwd_be=4'hf, ld_fwd_data=0xc0debbaa.
- Same sequence with MERGE_EN=0 -> count=4; st_ready=0; a further sw is stalled. One mem_ready pulse gives count=3 and st_ready=1 next cycle; drains occur in program order.
- sh to 0x1001 and sw to 0x1002 -> st_err pulses 1 cycle after each handshake; count stays 0; mem_we stays 0.
- DEPTH=4: enqueue while popping every cycle for 10 stores -> pointers wrap; mem_addr sequence matches input order; count never exceeds 1. Assert rst mid-stream -> mem_we=0 and count=0 next cycle.
